// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : state encodings, spawn coordinates and default game constants
// Revision : 1.0
// ============================================================================
package game_pkg;

  localparam logic [2:0] S_RUNNING   = 3'd0;
  localparam logic [2:0] S_GAME_OVER = 3'd1;
  localparam logic [2:0] S_WIN       = 3'd2;
  localparam logic [2:0] S_TITLE     = 3'd3;
  localparam logic [2:0] S_DYING     = 3'd4;
  localparam logic [2:0] S_VICTORY   = 3'd5;

  localparam int c_def_num_levels  = 3;
  localparam int c_def_start_lives = 3;
  localparam int c_def_death_ticks = 60;
  localparam int c_def_clear_ticks = 90;

  localparam logic [9:0] c_spawn_x       = 10'd20;
  localparam logic [9:0] c_spawn_y_first = 10'd344;
  localparam logic [9:0] c_spawn_y_later = 10'd364;

  // Level 0 starts on a higher ledge than every later level.
  function automatic logic [9:0] spawn_y(input logic [1:0] level);
    return (level == 2'd0) ? c_spawn_y_first : c_spawn_y_later;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
// tick_timer : 8-bit tick-paced countdown with load and zero flag
// Revision   : 1.0
// ============================================================================
module tick_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic [7:0] i_load_val,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_tick) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_dec && (r_count != 8'd0)) begin
        r_count <= r_count - 8'd1;
      end
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
// level_sequencer : game flow FSM (title, run, death/clear pauses, end screens)
// Revision        : 1.0
// ============================================================================
module level_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS  = c_def_num_levels,
  parameter int START_LIVES = c_def_start_lives,
  parameter int DEATH_TICKS = c_def_death_ticks,
  parameter int CLEAR_TICKS = c_def_clear_ticks
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic        start,
  input  logic        in_lava,
  input  logic        hit_lava_wall,
  input  logic        at_goal_region,
  input  logic        jump_landed_pulse,
  output logic [2:0]  game_state,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        freeze,
  output logic        respawn_pulse,
  output logic [9:0]  player_x_reset,
  output logic [9:0]  player_y_reset,
  output logic        speed_boost_pulse
);

  localparam logic [1:0] c_last_level  = 2'(NUM_LEVELS - 1);
  localparam logic [1:0] c_start_lives = 2'(START_LIVES);
  localparam logic [7:0] c_death_load  = 8'(DEATH_TICKS - 1);
  localparam logic [7:0] c_clear_load  = 8'(CLEAR_TICKS - 1);

  logic [2:0]  r_state;
  logic [1:0]  r_level;
  logic [1:0]  r_lives;
  logic [15:0] r_score;
  logic        r_respawn;
  logic        r_boost;
  logic        r_sticky;

  logic [2:0]  w_next_state;
  logic [1:0]  w_next_level;
  logic [1:0]  w_next_lives;
  logic        w_clear_score;
  logic        w_enter_run;
  logic        w_load;
  logic [7:0]  w_load_val;
  logic        w_dec;
  logic        w_timer_zero;
  logic        w_landing;

  tick_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (game_tick),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (w_load_val),
    .o_zero     (w_timer_zero)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_level  = r_level;
    w_next_lives  = r_lives;
    w_clear_score = 1'b0;
    w_enter_run   = 1'b0;
    w_load        = 1'b0;
    w_load_val    = 8'd0;
    case (r_state)
      S_TITLE, S_GAME_OVER, S_VICTORY: begin
        if (start) begin
          w_next_state  = S_RUNNING;
          w_next_level  = 2'd0;
          w_next_lives  = c_start_lives;
          w_clear_score = 1'b1;
          w_enter_run   = 1'b1;
        end
      end
      S_RUNNING: begin
        // Touching lava beats reaching the goal on the same tick.
        if (in_lava || hit_lava_wall) begin
          w_next_state = S_DYING;
          w_load       = 1'b1;
          w_load_val   = c_death_load;
        end else if (at_goal_region) begin
          w_next_state = S_WIN;
          w_load       = 1'b1;
          w_load_val   = c_clear_load;
        end
      end
      S_DYING: begin
        if (w_timer_zero) begin
          w_next_lives = r_lives - 2'd1;
          if (r_lives == 2'd1) begin
            w_next_state = S_GAME_OVER;
          end else begin
            w_next_state = S_RUNNING;
            w_enter_run  = 1'b1;
          end
        end
      end
      S_WIN: begin
        if (w_timer_zero) begin
          if (r_level == c_last_level) begin
            w_next_state = S_VICTORY;
          end else begin
            w_next_level = r_level + 2'd1;
            w_next_state = S_RUNNING;
            w_enter_run  = 1'b1;
          end
        end
      end
      default: w_next_state = S_TITLE;
    endcase
  end

  assign w_dec     = (r_state == S_DYING) || (r_state == S_WIN);
  assign w_landing = (r_state == S_RUNNING) && (jump_landed_pulse || r_sticky);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_TITLE;
      r_level   <= 2'd0;
      r_lives   <= c_start_lives;
      r_score   <= 16'd0;
      r_respawn <= 1'b0;
      r_boost   <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_respawn <= 1'b0;
      r_boost   <= 1'b0;
      if (game_tick) begin
        r_state   <= w_next_state;
        r_level   <= w_next_level;
        r_lives   <= w_next_lives;
        r_respawn <= w_enter_run;
        r_sticky  <= 1'b0;
        if (w_clear_score) begin
          r_score <= 16'd0;
        end else if (w_landing) begin
          r_boost <= 1'b1;
          if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
        end
      end else if (jump_landed_pulse && (r_state == S_RUNNING)) begin
        // A landing between ticks is remembered and credited on the next tick.
        r_sticky <= 1'b1;
      end
    end
  end

  assign game_state        = r_state;
  assign level             = r_level;
  assign lives             = r_lives;
  assign score             = r_score;
  assign freeze            = (r_state != S_RUNNING);
  assign respawn_pulse     = r_respawn;
  assign speed_boost_pulse = r_boost;
  assign player_x_reset    = c_spawn_x;
  assign player_y_reset    = spawn_y(r_level);

endmodule
`default_nettype wire

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_LEVELS, default 3, number of levels; START_LIVES, default 3, lives at game start; DEATH_TICKS, default 60, death-pause length in ticks; CLEAR_TICKS, default 90, level-clear pause length in ticks.
REQ-002 clk  input  1  system clock (CLOCK_50 domain).
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 game_tick  input  1  one-clk 60 Hz strobe.
REQ-005 start  input  1  level-sensitive start/restart request.
REQ-006 in_lava  input  1  player overlaps rising lava.
REQ-007 hit_lava_wall  input  1  player touched lava wall.
REQ-008 at_goal_region  input  1  player in goal.
REQ-009 jump_landed_pulse  input  1  one-clk landing strobe.
REQ-010 game_state  output  3  current state encoding.
REQ-011 level  output  2  current level index.
REQ-012 lives  output  2  remaining lives.
REQ-013 score  output  16  landings counter.
REQ-014 freeze  output  1  halts physics and lava.
REQ-015 respawn_pulse  output  1  one-clk strobe to reload the player at the reset position.
REQ-016 player_x_reset / player_y_reset  output  10 each  spawn coordinates.
REQ-017 speed_boost_pulse  output  1  one-clk lava speed-boost strobe.

Function
REQ-018 States SHALL be S_RUNNING=0, S_GAME_OVER=1, S_WIN=2, S_TITLE=3, S_DYING=4, S_VICTORY=5; other encodings SHALL return to S_TITLE on the next tick.
REQ-019 State, timer, level, lives and score SHALL change only on clk edges where game_tick=1.
REQ-020 S_TITLE, S_GAME_OVER or S_VICTORY with start=1 on a tick SHALL go to S_RUNNING with level=0, lives=START_LIVES, score=0 and assert respawn_pulse.
REQ-021 In S_RUNNING, in_lava or hit_lava_wall on a tick SHALL go to S_DYING and load the timer with DEATH_TICKS-1; death SHALL take priority over at_goal_region on the same tick.
REQ-022 In S_RUNNING, at_goal_region without death SHALL go to S_WIN and load the timer with CLEAR_TICKS-1.
REQ-023 In S_DYING, the timer SHALL decrement each tick; at 0, lives SHALL decrement.
REQ-024 When the S_DYING timer reaches 0, the FSM SHALL go to S_GAME_OVER if lives was 1; otherwise it SHALL go to S_RUNNING at the same level with respawn_pulse asserted.
REQ-025 In S_WIN, the timer SHALL decrement each tick; at 0, the FSM SHALL go to S_VICTORY if level==NUM_LEVELS-1.
REQ-026 At S_WIN timer 0 with level<NUM_LEVELS-1, the FSM SHALL set level+1 and go to S_RUNNING with respawn_pulse asserted.
REQ-027 jump_landed_pulse in S_RUNNING SHALL increment score, saturating at 16'hFFFF, and assert speed_boost_pulse for one clk; it SHALL be captured in a sticky flag if it falls between ticks and applied at the next tick.
REQ-028 freeze SHALL be 0 only in S_RUNNING.
REQ-029 respawn_pulse SHALL be high for exactly one clk, the cycle after the tick edge causing entry to S_RUNNING.
REQ-030 player_x_reset SHALL be 20; player_y_reset SHALL be 344 for level 0 and 364 otherwise, combinational from level.
REQ-031 start held high in S_RUNNING, S_DYING or S_WIN SHALL be ignored.

Reset
REQ-032 On rst low, outputs SHALL immediately become: game_state=S_TITLE, level=0, lives=START_LIVES, score=0, freeze=1, respawn_pulse=0, speed_boost_pulse=0, timer=0, sticky flag=0.
REQ-033 Reset asserted mid-timer or mid-pulse SHALL abort the sequence with no residual pulse after release.

Structure
REQ-034 State encodings, spawn coordinates and default parameter values SHALL live in shared package game_pkg.
REQ-035 The countdown SHALL be one sub-module, tick_timer: 8-bit, with load, decrement-on-tick and zero flag.

Verification
REQ-036 Reset, then start=1 for one tick -> S_RUNNING, level 0, lives 3, respawn_pulse one clk, spawn (20,344).
REQ-037 in_lava and at_goal_region on the same tick -> S_DYING; 60 ticks later lives=2, S_RUNNING, respawn_pulse.
REQ-038 Three deaths -> S_GAME_OVER with lives=0 and freeze=1; start -> lives=3, score=0.
REQ-039 Goal on level 0 -> S_WIN for 90 ticks -> level 1, spawn y=364; goal on level 2 -> S_VICTORY.
REQ-040 jump_landed_pulse mid-tick with score=16'hFFFE, then another -> score 16'hFFFF held, two speed_boost_pulse strobes.
REQ-041 rst low during S_DYING at timer=30 -> S_TITLE immediately, no respawn_pulse after release.
